// File: rtl/dbgmon_pkg.sv
// dbgmon_pkg: shared types and index-mapping helpers for the register-file debug monitor.
package dbgmon_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DISP_W = 16;
  localparam int NPAGES = DEF_DATA_W / DEF_DISP_W;
  localparam int PAGE_W = $clog2(NPAGES) + 1;
  typedef enum logic {MANUAL, AUTO} idx_mode_e;
  function automatic int sel_to_idx(input logic [31:0] s, input int n, input int base, input int dflt);
    sel_to_idx = dflt;
    for (int i = n - 1; i >= 0; i--) if (s[i]) sel_to_idx = base + i;
  endfunction
  function automatic int next_scan_idx(input int idx, input int n, input int base, input int dflt);
    return (idx >= base && idx < base + n - 1) ? idx + 1 : (idx == base + n - 1) ? dflt : base;
  endfunction
endpackage

// File: rtl/regfile_debug_monitor_sync2.sv
// sync2: width-parametrised two-flop synchroniser with synchronous reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q;
  always_ff @(posedge clk)
    if (rst) {q_o, s1_q} <= '0;
    else     {q_o, s1_q} <= {s1_q, d_i};
endmodule

// File: rtl/regfile_debug_monitor.sv
// regfile_debug_monitor: synchronised, paged, freezable viewer of one register-file entry.
module regfile_debug_monitor #(
  parameter int DATA_W      = dbgmon_pkg::DEF_DATA_W,
  parameter int DISP_W      = dbgmon_pkg::DEF_DISP_W,
  parameter int ADDR_W      = 5,
  parameter int NUM_SEL     = 10,
  parameter int SEL_BASE    = 20,
  parameter int DEFAULT_REG = 31,
  parameter int SCAN_DIV    = 50_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SEL-1:0]                 sel,
  input  logic                               mode_auto,
  input  logic                               page_btn,
  input  logic                               freeze,
  output logic [ADDR_W-1:0]                  rf_addr,
  input  logic [DATA_W-1:0]                  rf_data,
  output logic [DISP_W-1:0]                  res,
  output logic [ADDR_W-1:0]                  cur_idx,
  output logic [$clog2(DATA_W/DISP_W):0]     page,
  output logic                               changed
);
  import dbgmon_pkg::*;
  localparam int NP = DATA_W / DISP_W;
  localparam int PW = $clog2(NP) + 1;
  localparam int CW = $clog2(SCAN_DIV);
  logic [NUM_SEL-1:0] sel_s2;
  logic mode_s2, btn_s2, frz_s2;
  sync2 #(.W(NUM_SEL + 3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({sel, mode_auto, page_btn, freeze}),
    .q_o ({sel_s2, mode_s2, btn_s2, frz_s2})
  );
  idx_mode_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_q, cur_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [PW-1:0] page_q, page_d;
  logic btn_q, chg_q, chg_d, wrap;
  always_comb begin
    state_d = mode_s2 ? AUTO : MANUAL;
    wrap = cnt_q == CW'(SCAN_DIV - 1);
    cnt_d = (mode_s2 && state_q == AUTO && !wrap) ? cnt_q + 1'b1 : '0;
    addr_d = !mode_s2 ? ADDR_W'(sel_to_idx(32'(sel_s2), NUM_SEL, SEL_BASE, DEFAULT_REG)) :
             (state_q == AUTO && wrap) ? ADDR_W'(next_scan_idx(int'(addr_q), NUM_SEL, SEL_BASE, DEFAULT_REG)) :
             addr_q;
    snap_d = frz_s2 ? snap_q : rf_data;
    cur_d = frz_s2 ? cur_q : addr_q;
    // same register: sticky set on a data difference; different register: clear
    chg_d = frz_s2 ? chg_q : (addr_q == cur_q) && (chg_q || rf_data != snap_q);
    page_d = (btn_s2 && !btn_q) ? ((page_q == PW'(NP - 1)) ? '0 : page_q + 1'b1) : page_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MANUAL;
      cnt_q <= '0;
      addr_q <= ADDR_W'(DEFAULT_REG);
      cur_q <= ADDR_W'(DEFAULT_REG);
      snap_q <= '0;
      page_q <= '0;
      btn_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      cur_q <= cur_d;
      snap_q <= snap_d;
      page_q <= page_d;
      btn_q <= btn_s2;
      chg_q <= chg_d;
    end
  end
  assign rf_addr = addr_q;
  assign cur_idx = cur_q;
  assign page = page_q;
  assign changed = chg_q;
  assign res = DISP_W'(snap_q >> (page_q * DISP_W));
endmodule
